// File: rtl/seg_scan_ctrl.sv
// Digit scanner for a 4-digit seven-segment display: drives the 4:1 digit-mux select
// and active-low anodes, one digit per DIV-cycle slot with a leading dark interval.
module seg_scan_ctrl #(
    parameter int unsigned DIV   = 100_000,
    parameter int unsigned BLANK = 4,
    localparam int unsigned CW   = $clog2(DIV)
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       en,
    input  logic [3:0] mask,
    output logic [1:0] s,
    output logic [3:0] an,
    output logic       frame_tick
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLANK = 2'd1,
        S_DRIVE = 2'd2
    } state_t;

    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
    localparam logic [CW-1:0] SLOT_LAST  = CW'(DIV - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    s_q, s_d;
    logic          tick_q, tick_d;

    logic          run;
    logic [1:0]    lowest_sel;
    logic [1:0]    next_sel;

    // First enabled digit scanning upward (mod 4) from base; base itself is tried first.
    function automatic logic [1:0] first_from(input logic [3:0] m, input logic [1:0] base);
        logic [1:0] idx;
        logic       found;
        first_from = base;
        found      = 1'b0;
        for (int unsigned k = 0; k < 4; k++) begin
            idx = base + 2'(k);
            if (!found && m[idx]) begin
                first_from = idx;
                found      = 1'b1;
            end
        end
    endfunction

    assign run        = en && (mask != 4'b0000);
    assign lowest_sel = first_from(mask, 2'd0);
    // Starting at s+1 makes the current digit the last candidate, so a lone digit repeats.
    assign next_sel   = first_from(mask, s_q + 2'd1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            s_q     <= '0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            tick_q  <= tick_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        tick_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (run) begin
                    state_d = S_BLANK;
                    s_d     = lowest_sel;
                end
            end

            S_BLANK: begin
                if (!run) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == BLANK_LAST) begin
                        state_d = S_DRIVE;
                    end
                end
            end

            S_DRIVE: begin
                if (!run) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == SLOT_LAST) begin
                    state_d = S_BLANK;
                    cnt_d   = '0;
                    s_d     = next_sel;
                    tick_d  = (next_sel <= s_q);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Anode gating uses the live mask so a digit can be darkened mid-slot.
    always_comb begin
        an = 4'b1111;
        if (state_q == S_DRIVE && mask[s_q]) begin
            an = ~(4'b0001 << s_q);
        end
    end

    assign s          = s_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with DIV=8, BLANK=2: a table of per-cycle vectors
// plus hand-written sequences for idle entry, restart, live masking and async reset.
module tb_seg_scan_ctrl;

    logic       clk;
    logic       reset_n;
    logic       en;
    logic [3:0] mask;
    logic [1:0] s;
    logic [3:0] an;
    logic       frame_tick;

    int unsigned n_total;
    int unsigned n_pass;

    typedef struct {
        logic       en;
        logic [3:0] mask;
        logic [1:0] s;
        logic [3:0] an;
        logic       tick;
    } vec_t;

    vec_t vecs[$];

    seg_scan_ctrl #(
        .DIV  (8),
        .BLANK(2)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (en),
        .mask      (mask),
        .s         (s),
        .an        (an),
        .frame_tick(frame_tick)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step();
    endtask

    // One full slot of 8 cycles: 2 dark, 6 lit (if the digit is enabled); tick only on cycle 0.
    task automatic add_slot(input logic [3:0] m, input logic [1:0] d, input logic t);
        vec_t v;
        logic [3:0] lit;
        lit = ~(4'b0001 << d);
        for (int unsigned c = 0; c < 8; c++) begin
            v.en   = 1'b1;
            v.mask = m;
            v.s    = d;
            v.an   = (c < 2 || !m[d]) ? 4'b1111 : lit;
            v.tick = (c == 0) ? t : 1'b0;
            vecs.push_back(v);
        end
    endtask

    initial begin
        int unsigned ticks;
        n_total = 0;
        n_pass  = 0;
        reset_n = 1'b1;
        en      = 1'b0;
        mask    = 4'b0000;

        add_slot(4'b1111, 2'd0, 1'b0);
        add_slot(4'b1111, 2'd1, 1'b0);
        add_slot(4'b1111, 2'd2, 1'b0);
        add_slot(4'b1111, 2'd3, 1'b0);
        add_slot(4'b1111, 2'd0, 1'b1);
        add_slot(4'b1111, 2'd1, 1'b0);
        add_slot(4'b1111, 2'd2, 1'b0);
        add_slot(4'b1111, 2'd3, 1'b0);
        add_slot(4'b0101, 2'd0, 1'b1);
        add_slot(4'b0101, 2'd2, 1'b0);
        add_slot(4'b0101, 2'd0, 1'b1);
        add_slot(4'b0101, 2'd2, 1'b0);
        add_slot(4'b1000, 2'd3, 1'b0);
        add_slot(4'b1000, 2'd3, 1'b1);

        #2 reset_n = 1'b0;
        #1;
        check("reset_an", 32'(an), 32'hF);
        check("reset_s", 32'(s), 32'h0);
        check("reset_tick", 32'(frame_tick), 32'h0);
        steps(2);
        reset_n = 1'b1;
        step();
        check("idle_en0_an", 32'(an), 32'hF);
        check("idle_en0_s", 32'(s), 32'h0);

        foreach (vecs[i]) begin
            en   = vecs[i].en;
            mask = vecs[i].mask;
            step();
            check($sformatf("vec%0d_s", i), 32'(s), 32'(vecs[i].s));
            check($sformatf("vec%0d_an", i), 32'(an), 32'(vecs[i].an));
            check($sformatf("vec%0d_tick", i), 32'(frame_tick), 32'(vecs[i].tick));
        end

        // mask cleared with en=1: idle, dark, s held, no ticks
        mask = 4'b0000;
        step();
        check("m0_s_hold", 32'(s), 32'h3);
        for (int unsigned i = 0; i < 5; i++) begin
            check("m0_an", 32'(an), 32'hF);
            check("m0_tick", 32'(frame_tick), 32'h0);
            step();
        end
        mask = 4'b1000;
        step();
        check("m8_c0_s", 32'(s), 32'h3);
        check("m8_c0_an", 32'(an), 32'hF);
        check("m8_c0_tick", 32'(frame_tick), 32'h0);
        step();
        check("m8_c1_an", 32'(an), 32'hF);
        step();
        check("m8_c2_an", 32'(an), 32'h7);
        ticks = 0;
        for (int unsigned i = 0; i < 16; i++) begin
            step();
            if (frame_tick) ticks++;
        end
        check("m8_tick_count", 32'(ticks), 32'd2);

        // en drop and full restart
        en = 1'b0;
        step();
        check("en0_an", 32'(an), 32'hF);
        en   = 1'b1;
        mask = 4'b1111;
        step();
        check("rs_c0_s", 32'(s), 32'h0);
        check("rs_c0_an", 32'(an), 32'hF);
        step();
        check("rs_c1_an", 32'(an), 32'hF);
        step();
        check("rs_c2_an", 32'(an), 32'hE);
        steps(19);
        check("d2c5_s", 32'(s), 32'h2);
        check("d2c5_an", 32'(an), 32'hB);
        en = 1'b0;
        step();
        check("d2_abort_an", 32'(an), 32'hF);
        check("d2_abort_s", 32'(s), 32'h2);
        check("d2_abort_tick", 32'(frame_tick), 32'h0);
        en = 1'b1;
        step();
        check("rs2_c0_s", 32'(s), 32'h0);
        check("rs2_c0_an", 32'(an), 32'hF);
        step();
        check("rs2_c1_an", 32'(an), 32'hF);
        step();
        check("rs2_c2_an", 32'(an), 32'hE);

        // live mask clear mid-drive on digit 1
        steps(10);
        check("d1c4_s", 32'(s), 32'h1);
        check("d1c4_an", 32'(an), 32'hD);
        mask = 4'b1101;
        #1;
        check("d1_masked_an", 32'(an), 32'hF);
        steps(3);
        check("d1c7_s", 32'(s), 32'h1);
        check("d1c7_an", 32'(an), 32'hF);
        step();
        check("after_d1_s", 32'(s), 32'h2);
        check("after_d1_tick", 32'(frame_tick), 32'h0);
        steps(8);
        check("slot_d3_s", 32'(s), 32'h3);
        check("slot_d3_tick", 32'(frame_tick), 32'h0);
        steps(8);
        check("wrap_d0_s", 32'(s), 32'h0);
        check("wrap_d0_tick", 32'(frame_tick), 32'h1);
        steps(8);
        check("skip_d1_s", 32'(s), 32'h2);
        check("skip_d1_tick", 32'(frame_tick), 32'h0);
        steps(3);
        check("d2_lit_an", 32'(an), 32'hB);

        // asynchronous reset between clock edges
        #2 reset_n = 1'b0;
        #1;
        check("async_an", 32'(an), 32'hF);
        check("async_s", 32'(s), 32'h0);
        check("async_tick", 32'(frame_tick), 32'h0);
        steps(2);
        reset_n = 1'b1;
        mask    = 4'b0100;
        step();
        check("post_rst_s", 32'(s), 32'h2);
        check("post_rst_an", 32'(an), 32'hF);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
